// File: rtl/mul_pkg.sv
// Shared encodings and default width for the iterative shift-add multiplier.
package mul_pkg;

   localparam int MUL_WIDTH = 32;

   typedef enum logic [1:0] {
      MUL_OP_MUL   = 2'b00,
      MUL_OP_UMULL = 2'b01,
      MUL_OP_SMULL = 2'b10,
      MUL_OP_RSVD  = 2'b11
   } mul_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_FIX  = 2'b10,
      S_DONE = 2'b11
   } mul_state_e;

endpackage

// File: rtl/mul_seq_if.sv
// Request/response bundle between the core (master) and the multiply sequencer (slave).
interface mul_seq_if import mul_pkg::*; #(parameter int WIDTH = MUL_WIDTH);

   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result_lo;
   logic [WIDTH-1:0] result_hi;

   modport master (output start, op, a, b, input busy, done, result_lo, result_hi);
   modport slave  (input start, op, a, b, output busy, done, result_lo, result_hi);

endinterface

// File: rtl/mul_seq_dp.sv
// Multiplier datapath: operand magnitudes, one add/shift step per strobe, final sign fix.
module mul_seq_dp import mul_pkg::*; #(
   parameter int WIDTH = MUL_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             load,
   input  logic             step,
   input  logic             fix,
   input  mul_op_e          op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             mplier_done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi
);

   localparam int PW = 2 * WIDTH;

   logic [PW-1:0]    mcand_q, mcand_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] res_lo_q, res_lo_d;
   logic [WIDTH-1:0] res_hi_q, res_hi_d;
   mul_op_e          op_q, op_d;
   logic             neg_q, neg_d;
   logic [PW-1:0]    fixed_acc;

   // 0x8000_0000 maps to itself, which is the correct unsigned magnitude.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic is_signed);
      return (is_signed && x[WIDTH-1]) ? -x : x;
   endfunction

   assign mplier_done = (mplier_q[WIDTH-1:1] == '0);
   assign fixed_acc   = neg_q ? -acc_q : acc_q;

   always_comb begin
      // NOTE: every target gets a default first so no path can infer a latch.
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      mplier_d = mplier_q;
      res_lo_d = res_lo_q;
      res_hi_d = res_hi_q;
      op_d     = op_q;
      neg_d    = neg_q;
      if (clr) begin
         mcand_d  = '0;
         acc_d    = '0;
         mplier_d = '0;
         res_lo_d = '0;
         res_hi_d = '0;
         op_d     = MUL_OP_MUL;
         neg_d    = 1'b0;
      end else if (load) begin
         mcand_d  = {{WIDTH{1'b0}}, magnitude(a, op == MUL_OP_SMULL)};
         mplier_d = magnitude(b, op == MUL_OP_SMULL);
         acc_d    = '0;
         op_d     = op;
         neg_d    = (op == MUL_OP_SMULL) & (a[WIDTH-1] ^ b[WIDTH-1]);
      end else if (step) begin
         if (mplier_q[0]) acc_d = acc_q + mcand_q;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
      end else if (fix) begin
         acc_d    = fixed_acc;
         res_lo_d = fixed_acc[WIDTH-1:0];
         res_hi_d = (op_q == MUL_OP_MUL) ? '0 : fixed_acc[PW-1:WIDTH];
      end
   end

   // NOTE: the working registers are plain flops, so all of them are reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         res_lo_q <= '0;
         res_hi_q <= '0;
         op_q     <= MUL_OP_MUL;
         neg_q    <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         mplier_q <= mplier_d;
         res_lo_q <= res_lo_d;
         res_hi_q <= res_hi_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
      end
   end

   assign result_lo = res_lo_q;
   assign result_hi = res_hi_q;

endmodule

// File: rtl/mul_seq.sv
// Multiply sequencer top: IDLE/RUN/FIX/DONE control around mul_seq_dp.
// Build option: define MUL_EARLY_EXIT_EN to leave RUN once the remaining multiplier bits are zero.
module mul_seq import mul_pkg::*; #(
   parameter int WIDTH = MUL_WIDTH
) (
   input  logic      clk,
   input  logic      reset_n,
   mul_seq_if.slave  bus
);

   localparam int CNT_W = $clog2(WIDTH);
`ifdef MUL_EARLY_EXIT_EN
   localparam bit EARLY_EXIT = 1'b1;
`else
   localparam bit EARLY_EXIT = 1'b0;
`endif

   mul_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             clr, load, step, fix;
   logic             mplier_done;
   logic             last_step;

   assign last_step = (cnt_q == CNT_W'(WIDTH - 1)) || (EARLY_EXIT && mplier_done);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      clr     = 1'b0;
      load    = 1'b0;
      step    = 1'b0;
      fix     = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (!bus.start) begin
               state_d = S_IDLE;
            end else if (mul_op_e'(bus.op) == MUL_OP_RSVD) begin
               clr     = 1'b1;
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               load    = 1'b1;
               cnt_d   = '0;
               state_d = S_RUN;
               busy_d  = 1'b1;
            end
         end
         S_RUN: begin
            step   = 1'b1;
            cnt_d  = cnt_q + CNT_W'(1);
            busy_d = 1'b1;
            if (last_step) state_d = S_FIX;
         end
         S_FIX: begin
            fix     = 1'b1;
            state_d = S_DONE;
            done_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   mul_seq_dp #(.WIDTH(WIDTH)) u_dp (
      .clk         (clk),
      .reset_n     (reset_n),
      .clr         (clr),
      .load        (load),
      .step        (step),
      .fix         (fix),
      .op          (mul_op_e'(bus.op)),
      .a           (bus.a),
      .b           (bus.b),
      .mplier_done (mplier_done),
      .result_lo   (bus.result_lo),
      .result_hi   (bus.result_hi)
   );

   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule
